// File: rtl/program_loader.sv
// Program loader: clears program memory, then receives a byte stream
// (4-byte little-endian word count followed by the image) and writes it into
// memory one 32-bit word at a time, holds the core in reset for HOLD_CYCLES
// cycles and then releases it.
//
// Ports:
//   clk        - single clock, rising edge
//   reset      - asynchronous active-low reset of the whole block
//   in_valid   - byte offered on in_data
//   in_data    - byte stream (length header, then image)
//   in_ready   - byte accepted this cycle when in_valid is also high
//   mem_we     - program-memory write strobe
//   mem_addr   - word address of the write
//   mem_wdata  - write data
//   cpu_reset  - active-high core reset, 1 = core held
//   done       - load finished and core released
//   error      - header length exceeded memory depth
module program_loader #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned HOLD_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        StClear,
        StLen,
        StData,
        StHold,
        StRun,
        StError
    } state_e;

    localparam logic [32:0]           Depth    = 33'(1) << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LastAddr = '1;
    localparam logic [ADDR_WIDTH-1:0] AddrOne  = ADDR_WIDTH'(1);
    localparam logic [7:0]            HoldLast = 8'(HOLD_CYCLES - 1);

    state_e                state_q, state_d;
    logic                  sync_q;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [23:0]           acc_q, acc_d;
    logic [31:0]           remain_q, remain_d;
    logic [7:0]            hold_q, hold_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] wa_q, wa_d;
    logic [31:0]           wd_q, wd_d;

    logic                  accept;
    logic [31:0]           word;

    assign in_ready  = (state_q == StLen) || (state_q == StData);
    assign accept    = in_valid && in_ready;
    // Newest byte lands on top; after four bytes the first one sits in [7:0].
    assign word      = {in_data, acc_q};

    // CLEAR writes come straight from the counter; DATA writes are a registered pulse.
    assign mem_we    = ((state_q == StClear) && sync_q) || we_q;
    assign mem_addr  = (state_q == StClear) ? addr_q : wa_q;
    assign mem_wdata = (state_q == StClear) ? 32'h0 : wd_q;
    assign cpu_reset = (state_q != StRun);
    assign done      = (state_q == StRun);
    assign error     = (state_q == StError);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        byte_cnt_d = byte_cnt_q;
        acc_d      = acc_q;
        remain_d   = remain_q;
        hold_d     = hold_q;
        we_d       = 1'b0;
        wa_d       = wa_q;
        wd_d       = wd_q;

        unique case (state_q)
            StClear: begin
                if (sync_q) begin
                    addr_d = addr_q + AddrOne;
                    if (addr_q == LastAddr) begin
                        state_d = StLen;
                    end
                end
            end
            StLen: begin
                if (accept) begin
                    acc_d      = word[31:8];
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        acc_d = '0;
                        if ({1'b0, word} > Depth) begin
                            state_d = StError;
                        end else if (word == 32'h0) begin
                            state_d = StHold;
                        end else begin
                            state_d  = StData;
                            remain_d = word;
                            addr_d   = '0;
                        end
                    end
                end
            end
            StData: begin
                if (accept) begin
                    acc_d      = word[31:8];
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        acc_d    = '0;
                        we_d     = 1'b1;
                        wa_d     = addr_q;
                        wd_d     = word;
                        addr_d   = addr_q + AddrOne;
                        remain_d = remain_q - 32'd1;
                        if (remain_q == 32'd1) begin
                            state_d = StHold;
                        end
                    end
                end
            end
            StHold: begin
                if (hold_q == HoldLast) begin
                    state_d = StRun;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            StRun, StError: begin
            end
            default: state_d = StClear;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StClear;
            sync_q     <= 1'b0;
            addr_q     <= '0;
            byte_cnt_q <= '0;
            acc_q      <= '0;
            remain_q   <= '0;
            hold_q     <= '0;
            we_q       <= 1'b0;
            wa_q       <= '0;
            wd_q       <= '0;
        end else begin
            state_q    <= state_d;
            // Single-stage release: CLEAR writes start after the first edge and
            // the first one is captured on the second edge after deassertion.
            sync_q     <= 1'b1;
            addr_q     <= addr_d;
            byte_cnt_q <= byte_cnt_d;
            acc_q      <= acc_d;
            remain_q   <= remain_d;
            hold_q     <= hold_d;
            we_q       <= we_d;
            wa_q       <= wa_d;
            wd_q       <= wd_d;
        end
    end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

    localparam int AW = 4;
    localparam int HC = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h0;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_reset;
    logic          done;
    logic          error;

    program_loader #(
        .ADDR_WIDTH (AW),
        .HOLD_CYCLES(HC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_reset(cpu_reset),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    wr_t exp_q[$];
    int  total = 0;
    int  bad = 0;
    int  gap = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic push_wr(input int a, input logic [31:0] d);
        wr_t e;
        e.a = AW'(a);
        e.d = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every strobe seen must match the head of the expected queue.
    always @(negedge clk) begin
        wr_t e;
        if (mem_we === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: got addr %h data %h want none", mem_addr,
                         mem_wdata);
            end else begin
                e = exp_q.pop_front();
                if (mem_addr !== e.a || mem_wdata !== e.d) begin
                    bad++;
                    $display("FAIL write: got addr %h data %h want addr %h data %h",
                             mem_addr, mem_wdata, e.a, e.d);
                end
            end
        end
    end

    // All stimulus tasks start and end at posedge + 1.
    task automatic send_byte(input logic [7:0] b);
        int n;
        for (int i = 0; i < gap; i++) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) chk("send_timeout", 32'(in_ready), 32'h1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic do_reset();
        int n;
        reset    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        chk("rst_flags", {29'h0, cpu_reset, done, error}, 32'h4);
        for (int a = 0; a < (1 << AW); a++) push_wr(a, 32'h0);
        reset = 1'b1;
        #1;
        chk("no_write_before_sync", 32'(mem_we), 32'h0);
        @(posedge clk);
        #1;
        chk("first_clear_after_edge1", {31'h0, mem_we}, 32'h1);
        n = 0;
        while (!in_ready && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("clear_cycles", 32'(n), 32'd16);
        chk("clear_writes_seen", 32'(exp_q.size()), 32'h0);
    endtask

    task automatic wait_done(input string name);
        int n;
        chk({name, "_ready_low"}, 32'(in_ready), 32'h0);
        n = 0;
        while (!done && n < 50) begin
            chk({name, "_held"}, 32'(cpu_reset), 32'h1);
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_hold_cycles"}, 32'(n), 32'(HC));
        chk({name, "_run_flags"}, {29'h0, cpu_reset, done, error}, 32'h2);
        repeat (3) @(posedge clk);
        #1;
        chk({name, "_writes_seen"}, 32'(exp_q.size()), 32'h0);
        chk({name, "_run_ready"}, 32'(in_ready), 32'h0);
    endtask

    initial begin
        logic [31:0] w;

        // Clear then basic load.
        do_reset();
        chk("ready_after_clear", 32'(in_ready), 32'h1);
        push_wr(0, 32'h0000_0013);
        push_wr(1, 32'h0000_006F);
        send_word(32'd2);
        send_word(32'h0000_0013);
        send_word(32'h0000_006F);
        wait_done("load");

        // Same stream with an idle cycle before every byte.
        do_reset();
        gap = 1;
        push_wr(0, 32'h0000_0013);
        push_wr(1, 32'h0000_006F);
        send_word(32'd2);
        send_word(32'h0000_0013);
        send_word(32'h0000_006F);
        wait_done("bp");
        gap = 0;

        // Full memory: N = depth.
        do_reset();
        send_word(32'd16);
        for (int i = 0; i < 16; i++) begin
            w = {8'(i), 8'hA5, 8'(i * 3), 8'(i + 1)};
            push_wr(i, w);
            send_word(w);
        end
        wait_done("full");

        // N = depth + 1 is rejected.
        do_reset();
        send_word(32'd17);
        chk("err_flags", {29'h0, cpu_reset, done, error}, 32'h5);
        chk("err_ready", 32'(in_ready), 32'h0);
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (20) @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("err_sticky", {29'h0, cpu_reset, done, error}, 32'h5);
        chk("err_no_writes", 32'(exp_q.size()), 32'h0);

        // Zero length goes straight to hold.
        do_reset();
        send_word(32'd0);
        wait_done("zero");

        // Reset in the middle of word 1.
        do_reset();
        push_wr(0, 32'h0000_0013);
        send_word(32'd2);
        send_word(32'h0000_0013);
        send_byte(8'h6F);
        send_byte(8'h00);
        reset = 1'b0;
        #1;
        chk("mid_mem_we", 32'(mem_we), 32'h0);
        chk("mid_mem_addr", 32'(mem_addr), 32'h0);
        chk("mid_mem_wdata", mem_wdata, 32'h0);
        chk("mid_flags", {28'h0, in_ready, cpu_reset, done, error}, 32'h4);
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        push_wr(0, 32'hDEAD_BEEF);
        send_word(32'd1);
        send_word(32'hDEAD_BEEF);
        wait_done("after_mid");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
